l2_tag_sram_ctrl: RTL and testbench

Requester-side controller for the 512×20 L2 tag SRAM macro, which is a single-port OpenRAM RW macro with active-low `csb0`/`web0`. It converts a valid/ready request stream from the L2 cache datapath into macro port cycles. It captures read data on the correct edge and returns it through a valid/ready response channel. The macro has no reset, so the controller also zero-initializes every tag entry after reset and on flush.

---
 rtl/l2_sram_pkg.sv | 14 +
 rtl/l2_tag_sram_ctrl.sv | 135 +++++++++++++
 tb/tb_l2_tag_sram_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_sram_pkg.sv
// Shared constants and state encoding for the L2 tag SRAM controller.
package l2_sram_pkg;

  localparam int L2_TAG_DATA_WIDTH = 20;
  localparam int L2_TAG_ADDR_WIDTH = 9;
  localparam int L2_TAG_DEPTH      = 1 << L2_TAG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    INIT       = 2'd0,
    IDLE       = 2'd1,
    FLUSH_WAIT = 2'd2
  } sram_ctrl_state_t;

endpackage

// File: rtl/l2_tag_sram_ctrl.sv
// Requester-side controller for the single-port L2 tag SRAM macro.
// It zero-fills the macro after reset and on flush, and turns a valid/ready
// request stream into macro cycles with a registered read response.
module l2_tag_sram_ctrl
  import l2_sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = L2_TAG_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = L2_TAG_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  flush,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  sram_ctrl_state_t      state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic                  read_pend;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  accept;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // Macro pins and request handshake: sweep writes in INIT, pass-through of
  // the accepted request in IDLE, quiet otherwise. Reset holds the pins idle
  // even though the state register already reads INIT.
  always_comb begin
    csb0      = 1'b1;
    web0      = 1'b1;
    addr0     = '0;
    din0      = '0;
    req_ready = 1'b0;
    case (state)
      INIT: begin
        if (!rst) begin
          csb0  = 1'b0;
          web0  = 1'b0;
          addr0 = sweep_cnt;
          din0  = INIT_VALUE;
        end
      end
      IDLE: begin
        req_ready = !rsp_valid || rsp_ready;
        csb0      = !(req_valid && req_ready);
        web0      = !req_we;
        addr0     = req_addr;
        din0      = req_wdata;
      end
      default: begin
      end
    endcase
  end

  // Control FSM: sweep, service, and drain-before-resweep on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (flush) begin
            state     <= FLUSH_WAIT;
            init_done <= 1'b0;
          end
        end
        FLUSH_WAIT: begin
          if (!read_pend && !rsp_valid && !skid_valid) begin
            state <= INIT;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Read return path. dout0 is only valid at the edge after acceptance, so it
  // is always captured then; if the consumer stalls on that very edge the
  // word parks in a one-entry skid register instead of being lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_pend  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      read_pend <= accept && !req_we;
      if (!rsp_valid || rsp_ready) begin
        if (skid_valid) begin
          rsp_valid  <= 1'b1;
          rsp_rdata  <= skid_data;
          skid_valid <= read_pend;
          if (read_pend) begin
            skid_data <= dout0;
          end
        end else if (read_pend) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= dout0;
        end else begin
          rsp_valid <= 1'b0;
        end
      end else if (read_pend) begin
        skid_valid <= 1'b1;
        skid_data  <= dout0;
      end
    end
  end

endmodule

// File: tb/tb_l2_tag_sram_ctrl.sv
// Scoreboard bench for l2_tag_sram_ctrl with a behavioral model of the
// OpenRAM tag macro attached to the macro pins.
module l2cache_tag_array (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [8:0]  addr0,
  input  logic [19:0] din0,
  output logic [19:0] dout0
);
  logic [19:0] mem [0:511];
  logic        csb_r = 1'b1;
  logic        web_r = 1'b1;
  logic [8:0]  addr_r = '0;
  logic [19:0] din_r = '0;

  initial dout0 = 20'hBAD5A;

  // Latch pins at the rising edge; read data becomes garbage shortly after.
  always @(posedge clk0) begin
    csb_r  = csb0;
    web_r  = web0;
    addr_r = addr0;
    din_r  = din0;
    #2 dout0 = 20'hBAD5A;
  end

  // Perform the latched access on the falling edge.
  always @(negedge clk0) begin
    if (!csb_r) begin
      if (!web_r) mem[addr_r] = din_r;
      else        dout0 = mem[addr_r];
    end
  end
endmodule

module tb_l2_tag_sram_ctrl;
  import l2_sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [19:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [19:0] rsp_rdata;
  logic        flush = 1'b0;
  logic        init_done;
  logic        csb0;
  logic        web0;
  logic [8:0]  addr0;
  logic [19:0] din0;
  logic [19:0] dout0;

  typedef struct {
    logic [19:0] data;
    int          cyc;
    bit          chk_lat;
  } rsp_exp_t;

  rsp_exp_t exp_q[$];
  rsp_exp_t exp_e;
  int       cyc = 0;
  int       vectors = 0;
  int       miscompares = 0;
  int       start_cyc;
  int       rel_cyc;

  l2_tag_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .flush(flush), .init_done(init_done),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  l2cache_tag_array macro (
    .clk0(clk), .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency and sweep-length checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: condition not met at cycle %0d", name, cyc);
  endtask

  // Monitor: pop the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        report_fail("unexpected_rsp");
      end else begin
        exp_e = exp_q.pop_front();
        check_output("rsp_rdata", rsp_rdata, exp_e.data);
        if (exp_e.chk_lat) check_output("rsp_latency", cyc - exp_e.cyc, 1);
      end
    end
  end

  task automatic check_reset_outputs();
    check_output("rst_csb0", csb0, 1);
    check_output("rst_web0", web0, 1);
    check_output("rst_addr0", addr0, 0);
    check_output("rst_din0", din0, 0);
    check_output("rst_req_ready", req_ready, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_rdata", rsp_rdata, 0);
    check_output("rst_init_done", init_done, 0);
  endtask

  // Issue one request (called just after a rising edge); for reads, data is
  // the expected response and is queued at the acceptance edge.
  task automatic apply_request(input logic we, input logic [8:0] addr,
                               input logic [19:0] data, input bit chk_lat);
    int waited = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      report_fail("req_accept_timeout");
      return;
    end
    @(posedge clk);
    #1;
    if (!we) exp_q.push_back('{data, cyc, chk_lat});
  endtask

  task automatic idle_request();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Follow a sweep until init_done, checking every write and its length.
  task automatic wait_sweep(output int first_cyc);
    int writes = 0;
    int bad = 0;
    int guard = 0;
    first_cyc = -1;
    @(negedge clk);
    while (!init_done && guard < 2000) begin
      if (!csb0 && !web0) begin
        if (writes == 0) first_cyc = cyc;
        if (addr0 !== writes[8:0] || din0 !== 20'h0) bad++;
        writes++;
      end
      if (req_ready) bad++;
      @(negedge clk);
      guard++;
    end
    check_output("sweep_done", init_done, 1);
    check_output("sweep_writes", writes, 512);
    check_output("sweep_order", bad, 0);
    check_output("sweep_cycles", cyc - first_cyc, 512);
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();

    // Sweep after reset release, then a read of the last entry.
    rst = 1'b0;
    rel_cyc = cyc;
    wait_sweep(start_cyc);
    check_output("sweep_start", start_cyc, rel_cyc);
    @(posedge clk); #1;
    apply_request(1'b0, 9'h1FF, 20'h0, 1'b1);
    idle_request();

    // Read-after-write to the same entry.
    apply_request(1'b1, 9'h005, 20'hABCDE, 1'b0);
    apply_request(1'b0, 9'h005, 20'hABCDE, 1'b1);
    idle_request();

    // Back-to-back reads with no bubbles.
    apply_request(1'b1, 9'h010, 20'h1, 1'b0);
    apply_request(1'b1, 9'h011, 20'h2, 1'b0);
    apply_request(1'b1, 9'h012, 20'h3, 1'b0);
    apply_request(1'b0, 9'h010, 20'h1, 1'b1);
    apply_request(1'b0, 9'h011, 20'h2, 1'b1);
    apply_request(1'b0, 9'h012, 20'h3, 1'b1);
    idle_request();

    // Consumer stalls right after two streamed reads; neither may be lost.
    apply_request(1'b0, 9'h010, 20'h1, 1'b0);
    apply_request(1'b0, 9'h011, 20'h2, 1'b0);
    rsp_ready = 1'b0;
    idle_request();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("stream_stall_rdata", rsp_rdata, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Held response blocks new requests.
    rsp_ready = 1'b0;
    apply_request(1'b0, 9'h011, 20'h2, 1'b0);
    idle_request();
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 9'h012;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("stall_req_ready", req_ready, 0);
      check_output("stall_csb0", csb0, 1);
      check_output("stall_rsp_valid", rsp_valid, 1);
      check_output("stall_rsp_rdata", rsp_rdata, 2);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    apply_request(1'b0, 9'h012, 20'h3, 1'b0);
    idle_request();
    repeat (3) @(posedge clk);
    #1;

    // Flush while a read response is held.
    apply_request(1'b1, 9'h040, 20'h3, 1'b0);
    rsp_ready = 1'b0;
    apply_request(1'b0, 9'h040, 20'h3, 1'b0);
    idle_request();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("flush_init_done", init_done, 0);
      check_output("flush_req_ready", req_ready, 0);
      check_output("flush_csb0", csb0, 1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_sweep(start_cyc);
    @(posedge clk); #1;
    apply_request(1'b0, 9'h040, 20'h0, 1'b1);
    idle_request();

    // Reset in the middle of a flush sweep.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!(!csb0 && !web0 && addr0 == 9'd200) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) report_fail("sweep_addr_200_timeout");
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    rel_cyc = cyc;
    wait_sweep(start_cyc);
    check_output("resweep_start", start_cyc, rel_cyc);
    @(posedge clk); #1;
    apply_request(1'b0, 9'h005, 20'h0, 1'b1);
    apply_request(1'b0, 9'h1FF, 20'h0, 1'b1);
    idle_request();

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check_output("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
